// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared constants, types and arithmetic helpers for the block accumulator.
//   - DEF_* : default geometry (sample width, lanes, block length, shift)
//   - out_state_e : output register occupancy (EMPTY / FULL)
//   - acc_width() : accumulator width that cannot overflow over one block
//   - sat_shift() : arithmetic right shift followed by saturation to data_w,
//                   returned as {sat_flag, result sign-extended to MAX_ACC_W}
// -----------------------------------------------------------------------------
package acc_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_N_CH   = 4;
    localparam int DEF_LEN    = 8;
    localparam int DEF_SHIFT  = 3;

    // Widest accumulator the helper functions operate on.
    localparam int MAX_ACC_W  = 64;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // One extra bit beyond the block growth keeps the sign of LEN full-scale
    // negative samples representable.
    function automatic int acc_width(input int data_w, input int len);
        return data_w + $clog2(len) + 1;
    endfunction

    // Floor-shift (no rounding) then clip to the signed data_w range.
    function automatic logic [MAX_ACC_W:0] sat_shift(
        input logic signed [MAX_ACC_W-1:0] sum,
        input int                          shift,
        input int                          data_w
    );
        logic signed [MAX_ACC_W-1:0] shifted;
        logic signed [MAX_ACC_W-1:0] max_v;
        logic signed [MAX_ACC_W-1:0] min_v;
        logic        [MAX_ACC_W:0]   res;
        shifted = sum >>> shift;
        max_v   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (data_w - 1));
        if (shifted > max_v) begin
            res = {1'b1, max_v};
        end else if (shifted < min_v) begin
            res = {1'b1, min_v};
        end else begin
            res = {1'b0, shifted};
        end
        return res;
    endfunction

endpackage

// File: rtl/acc_lane.sv
// -----------------------------------------------------------------------------
// acc_lane
// One accumulation lane: running sum register plus the scaled, saturated
// result register that feeds the shared output stage.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous abort of the partial block (zeroes the sum)
//   xfer          : a sample is consumed this cycle
//   blk_end       : the consumed sample completes the block
//   in_sample     : signed sample for this lane
//   out_data      : held scaled/saturated block result
//   out_sat       : result was clipped
// -----------------------------------------------------------------------------
module acc_lane
    import acc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN    = DEF_LEN,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              xfer,
    input  logic              blk_end,
    input  logic [DATA_W-1:0] in_sample,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat
);

    localparam int ACC_W = acc_width(DATA_W, LEN);

    logic signed [ACC_W-1:0]     acc_q;
    logic signed [ACC_W-1:0]     acc_d;
    logic signed [ACC_W-1:0]     sample_ext_s;
    logic signed [ACC_W-1:0]     sum_s;
    logic signed [MAX_ACC_W-1:0] sum_wide_s;
    logic        [MAX_ACC_W:0]   sat_full_s;
    logic        [DATA_W-1:0]    res_s;
    logic                        flag_s;
    logic                        unused_hi_s;
    logic        [DATA_W-1:0]    out_data_q;
    logic        [DATA_W-1:0]    out_data_d;
    logic                        out_sat_q;
    logic                        out_sat_d;

    assign sample_ext_s = ACC_W'($signed(in_sample));
    assign sum_s        = acc_q + sample_ext_s;
    assign sum_wide_s   = MAX_ACC_W'(sum_s);
    assign sat_full_s   = sat_shift(sum_wide_s, SHIFT, DATA_W);
    assign res_s        = sat_full_s[DATA_W-1:0];
    assign flag_s       = sat_full_s[MAX_ACC_W];
    // Upper bits are pure sign extension of an in-range value.
    assign unused_hi_s  = ^sat_full_s[MAX_ACC_W-1:DATA_W];

    // Next accumulator value: abort, restart at block end, or add the sample.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = {ACC_W{1'b0}};
        end else if (blk_end) begin
            acc_d = {ACC_W{1'b0}};
        end else if (xfer) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Result register captures the final sum (including the last sample).
    always_comb begin
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (blk_end) begin
            out_data_d = res_s;
            out_sat_d  = flag_s;
        end else begin
            out_data_d = out_data_q;
            out_sat_d  = out_sat_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= {ACC_W{1'b0}};
            out_data_q <= {DATA_W{1'b0}};
            out_sat_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign out_data = out_data_q;
    assign out_sat  = out_sat_q;

endmodule

// File: rtl/block_accumulator.sv
// -----------------------------------------------------------------------------
// block_accumulator
// Multi-lane accumulate-and-dump: sums LEN accepted samples per lane, scales
// by an arithmetic right shift of SHIFT, saturates to DATA_W and offers the
// result through a one-entry valid/ready register, then restarts.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous abort of the partial block
//   in_valid   : sample vector valid       in_ready : sample can be taken
//   in_data    : lane i at [i*DATA_W +: DATA_W], signed
//   out_valid  : result held               out_ready: consumer takes result
//   out_data   : per-lane result           out_sat  : per-lane clip flag
//   blk_cnt    : samples accumulated in the current block
// -----------------------------------------------------------------------------
module block_accumulator
    import acc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH,
    parameter int LEN    = DEF_LEN,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_sat,
    output logic [$clog2(LEN+1)-1:0] blk_cnt
);

    localparam int               CNT_W    = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    logic [CNT_W-1:0] blk_cnt_q;
    logic [CNT_W-1:0] blk_cnt_d;
    out_state_e       state_q;
    out_state_e       state_d;
    logic             last_s;
    logic             in_ready_s;
    logic             xfer_s;
    logic             blk_end_s;

    assign last_s = (blk_cnt_q == LAST_CNT);

    // Only the block-completing sample can be blocked by a full, undrained
    // output register; a drain on the same edge frees the slot in time.
    assign in_ready_s = !clear && !(last_s && (state_q == OUT_FULL) && !out_ready);
    assign xfer_s     = in_valid && in_ready_s;
    assign blk_end_s  = xfer_s && last_s;

    // Sample counter within the current block.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (clear) begin
            blk_cnt_d = {CNT_W{1'b0}};
        end else if (blk_end_s) begin
            blk_cnt_d = {CNT_W{1'b0}};
        end else if (xfer_s) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
        end else begin
            blk_cnt_d = blk_cnt_q;
        end
    end

    // Output register occupancy; drain and refill on one edge stays FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: begin
                if (blk_end_s) begin
                    state_d = OUT_FULL;
                end else begin
                    state_d = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (out_ready) begin
                    if (blk_end_s) begin
                        state_d = OUT_FULL;
                    end else begin
                        state_d = OUT_EMPTY;
                    end
                end else begin
                    state_d = OUT_FULL;
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q <= {CNT_W{1'b0}};
            state_q   <= OUT_EMPTY;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            state_q   <= state_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_lane
            acc_lane #(
                .DATA_W (DATA_W),
                .LEN    (LEN),
                .SHIFT  (SHIFT)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .clear     (clear),
                .xfer      (xfer_s),
                .blk_end   (blk_end_s),
                .in_sample (in_data[g*DATA_W +: DATA_W]),
                .out_data  (out_data[g*DATA_W +: DATA_W]),
                .out_sat   (out_sat[g])
            );
        end
    endgenerate

    assign in_ready  = in_ready_s;
    assign out_valid = (state_q == OUT_FULL);
    assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_block_accumulator.sv
// Scoreboard bench for block_accumulator: stimulus pushes hand-computed
// results, a negedge monitor pops and compares on every output handshake.
module tb_block_accumulator;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        clear      = 1'b0;
    logic        in_valid_a = 1'b0;
    logic        in_valid_b = 1'b0;
    logic        out_ready  = 1'b1;
    logic [31:0] in_data    = 32'd0;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_data_a, out_data_b;
    logic [1:0]  out_sat_a, out_sat_b;
    logic [2:0]  blk_cnt_a, blk_cnt_b;

    // Main DUT: 2 lanes, LEN=4, SHIFT=2.
    block_accumulator #(.DATA_W(16), .N_CH(2), .LEN(4), .SHIFT(2)) dut_a (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_sat(out_sat_a), .blk_cnt(blk_cnt_a)
    );

    // Saturation DUT: same geometry, SHIFT=1.
    block_accumulator #(.DATA_W(16), .N_CH(2), .LEN(4), .SHIFT(1)) dut_b (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_sat(out_sat_b), .blk_cnt(blk_cnt_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          sel;
        logic [31:0] data;
        logic [1:0]  sat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int sel, input logic [15:0] l0, input logic [15:0] l1,
                        input logic [1:0] sat, input int c);
        exp_t e;
        e.sel  = sel;
        e.data = {l1, l0};
        e.sat  = sat;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int sel, input logic [31:0] d, input logic [1:0] s);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected dut=%0d actual=%0h expected=no result", sel, d);
        end else begin
            e = sb.pop_front();
            check("sb_dut", 64'(sel), 64'(e.sel));
            check("sb_data", 64'(d), 64'(e.data));
            check("sb_sat", 64'(s), 64'(e.sat));
            if (e.cyc >= 0) begin
                check("sb_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    endtask

    // Monitor: compare every accepted result against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_a && out_ready) pop_cmp(0, out_data_a, out_sat_a);
            if (out_valid_b && out_ready) pop_cmp(1, out_data_b, out_sat_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for one cycle; it must be accepted.
    task automatic send(input int sel, input logic [15:0] l0, input logic [15:0] l1);
        in_data = {l1, l0};
        if (sel == 0) in_valid_a = 1'b1;
        else          in_valid_b = 1'b1;
        @(negedge clk);
        check("in_ready", 64'((sel == 0) ? in_ready_a : in_ready_b), 64'd1);
        step();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    int exp0[3] = '{1, 5, 9};
    int exp1[3] = '{-2, -6, -10};

    initial begin
        int c0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_blk_cnt", 64'(blk_cnt_a), 64'd0);
        check("rst_out_data", 64'(out_data_a), 64'd0);
        check("rst_out_sat", 64'(out_sat_a), 64'd0);
        check("rst_in_ready", 64'(in_ready_a), 64'd1);
        step();
        rst = 1'b0;

        // 1: basic block, floor toward -inf on lane 1.
        send(0, 16'd100, -16'sd1);
        send(0, 16'd200, -16'sd2);
        send(0, 16'd300, -16'sd3);
        send(0, 16'd400, -16'sd4);
        push(0, 16'd250, -16'sd3, 2'b00, cyc);
        step();
        @(negedge clk);
        check("t1_single_pulse", 64'(out_valid_a), 64'd0);
        step();

        // 2: saturation both directions (SHIFT=1 instance).
        repeat (4) send(1, 16'h7FFF, 16'h8000);
        push(1, 16'h7FFF, 16'h8000, 2'b11, cyc);
        step();
        step();

        // 3: backpressure stalls only the block-completing sample.
        out_ready = 1'b0;
        repeat (4) send(0, 16'd10, -16'sd20);
        push(0, 16'd10, -16'sd20, 2'b00, -1);
        repeat (3) send(0, 16'd20, 16'd0);
        in_data    = {16'd4, 16'd20};
        in_valid_a = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t3_stall_ready", 64'(in_ready_a), 64'd0);
            check("t3_hold_valid", 64'(out_valid_a), 64'd1);
            check("t3_hold_data", 64'(out_data_a), 64'h0000_0000_FFEC_000A);
            check("t3_stall_cnt", 64'(blk_cnt_a), 64'd3);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_release_ready", 64'(in_ready_a), 64'd1);
        step();
        in_valid_a = 1'b0;
        push(0, 16'd20, 16'd1, 2'b00, cyc);
        step();
        step();

        // 4: clear aborts a partial block and blocks the concurrent sample.
        send(0, 16'd1000, 16'd1000);
        send(0, 16'd1000, 16'd1000);
        clear      = 1'b1;
        in_valid_a = 1'b1;
        in_data    = {16'd999, 16'd999};
        @(negedge clk);
        check("t4_cnt_before", 64'(blk_cnt_a), 64'd2);
        check("t4_clear_ready", 64'(in_ready_a), 64'd0);
        step();
        clear      = 1'b0;
        in_valid_a = 1'b0;
        @(negedge clk);
        check("t4_cnt_cleared", 64'(blk_cnt_a), 64'd0);
        step();
        repeat (4) send(0, 16'd8, -16'sd8);
        push(0, 16'd8, -16'sd8, 2'b00, cyc);
        step();

        // 5: asynchronous reset mid-block with a held result.
        out_ready = 1'b0;
        repeat (4) send(0, 16'd12, 16'd12);
        send(0, 16'd1, 16'd1);
        send(0, 16'd1, 16'd1);
        @(negedge clk);
        check("t5_pre_valid", 64'(out_valid_a), 64'd1);
        check("t5_pre_cnt", 64'(blk_cnt_a), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", 64'(out_valid_a), 64'd0);
        check("t5_async_cnt", 64'(blk_cnt_a), 64'd0);
        check("t5_async_data", 64'(out_data_a), 64'd0);
        check("t5_async_sat", 64'(out_sat_a), 64'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (4) send(0, 16'd4, -16'sd4);
        push(0, 16'd4, -16'sd4, 2'b00, cyc);
        step();

        // 6: continuous ramp, one result every LEN cycles.
        c0 = cyc;
        for (int k = 0; k < 12; k++) begin
            send(0, 16'(k), 16'(-k));
            if ((k % 4) == 3) begin
                push(0, 16'(exp0[k/4]), 16'(exp1[k/4]), 2'b00, c0 + k + 1);
            end
        end
        step();
        step();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
